// File: rtl/arm_alu_pkg.sv
// Shared ALU definitions: opcode encoding, FSM states and flag bit positions.
// Used by arm_alu_seq, its multiplier datapath and the decoder/control unit.
package arm_alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_MOV  = 3'b010;
    localparam logic [OP_W-1:0] OP_LSR  = 3'b011;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_PASS = 3'b110;

    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_CARRY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    // Assemble the flag vector from its individual bits.
    function automatic logic [FLAG_W-1:0] make_flags(input logic neg, input logic zero,
                                                     input logic carry);
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        return f;
    endfunction

endpackage

// File: rtl/arm_alu_seq_if.sv
// Request/result bundle between the control unit (master) and arm_alu_seq (slave).
interface arm_alu_seq_if #(
    parameter int unsigned DATA_W = 16
);
    import arm_alu_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op;
    logic              cin;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rs_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] d_out;
    logic [FLAG_W-1:0] flags;

    modport master (
        output start, op, cin, rd_data, rs_data,
        input  busy, done, d_out, flags
    );

    modport slave (
        input  start, op, cin, rd_data, rs_data,
        output busy, done, d_out, flags
    );

endinterface

// File: rtl/arm_alu_mul_iter.sv
// Shift-add multiplier datapath: one multiplier bit per step, low DATA_W bits kept.
// ARM_ALU_EARLY_EXIT_EN: report completion as soon as the remaining multiplier is zero.
module arm_alu_mul_iter #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] mplier,
    input  logic [DATA_W-1:0] mcand,
    output logic [DATA_W-1:0] acc_next_c,
    output logic              finished_c
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CNT_W-1:0]  cnt;
    logic              last_iter_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            a   <= '0;
            b   <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            a   <= mplier;
            b   <= mcand;
            cnt <= '0;
        end else if (step) begin
            acc <= acc_next_c;
            a   <= a >> 1;
            b   <= b << 1;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Accumulator value after the step currently in progress.
    assign acc_next_c  = a[0] ? (acc + b) : acc;
    assign last_iter_c = (cnt == CNT_W'(DATA_W - 1));

`ifdef ARM_ALU_EARLY_EXIT_EN
    assign finished_c = last_iter_c || (a[DATA_W-1:1] == '0);
`else
    assign finished_c = last_iter_c;
`endif

endmodule

// File: rtl/arm_alu_seq.sv
// Registered ARM-path ALU with start/done handshake and iterative multiply.
// Build option ARM_ALU_EARLY_EXIT_EN shortens multiplies with small multipliers.
module arm_alu_seq
    import arm_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    arm_alu_seq_if.slave bus
);

    state_e            state;
    state_e            state_d;

    logic [OP_W-1:0]   op_q;
    logic              cin_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;

    logic              capture_c;
    logic              mul_load_c;
    logic              mul_step_c;
    logic [DATA_W-1:0] mul_acc_next_c;
    logic              mul_finished_c;

    logic [DATA_W:0]   sum_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              alu_carry_c;

    arm_alu_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mul_load_c),
        .step       (mul_step_c),
        .mplier     (bus.rd_data),
        .mcand      (bus.rs_data),
        .acc_next_c (mul_acc_next_c),
        .finished_c (mul_finished_c)
    );

    // Single-cycle operations on the captured operands.
    always_comb begin
        sum_c       = '0;
        alu_res_c   = a_q;
        alu_carry_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_c       = {1'b0, a_q} + {1'b0, b_q};
                alu_res_c   = sum_c[DATA_W-1:0];
                alu_carry_c = sum_c[DATA_W];
            end
            OP_SUB: begin
                sum_c       = {1'b0, a_q} + {1'b0, ~b_q} + (DATA_W + 1)'(1);
                alu_res_c   = sum_c[DATA_W-1:0];
                alu_carry_c = sum_c[DATA_W];
            end
            OP_MOV: begin
                sum_c       = {1'b0, b_q} + (DATA_W + 1)'(cin_q);
                alu_res_c   = sum_c[DATA_W-1:0];
                alu_carry_c = sum_c[DATA_W];
            end
            OP_LSR: begin
                alu_res_c   = b_q >> 1;
                alu_carry_c = b_q[0];
            end
            OP_DEC: begin
                alu_res_c   = b_q - DATA_W'(1);
            end
            default: begin
                alu_res_c   = a_q;
            end
        endcase
    end

    // Control FSM: next state and next values of the registered outputs.
    always_comb begin
        state_d    = state;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dout_d     = dout_q;
        flags_d    = flags_q;
        capture_c  = 1'b0;
        mul_load_c = 1'b0;
        mul_step_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    capture_c  = 1'b1;
                    busy_d     = 1'b1;
                    if (bus.op == OP_MUL) begin
                        mul_load_c = 1'b1;
                        state_d    = ST_MUL;
                    end else begin
                        state_d    = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dout_d  = alu_res_c;
                flags_d = make_flags(alu_res_c[DATA_W-1], alu_res_c == '0, alu_carry_c);
            end
            ST_MUL: begin
                mul_step_c = 1'b1;
                if (mul_finished_c) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = mul_acc_next_c;
                    flags_d = make_flags(mul_acc_next_c[DATA_W-1], mul_acc_next_c == '0, 1'b0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            flags_q <= '0;
            op_q    <= OP_ADD;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state   <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            flags_q <= flags_d;
            if (capture_c) begin
                op_q  <= bus.op;
                cin_q <= bus.cin;
                a_q   <= bus.rd_data;
                b_q   <= bus.rs_data;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d_out = dout_q;
    assign bus.flags = flags_q;

endmodule

// File: tb/tb_arm_alu_seq.sv
// Directed bench for arm_alu_seq (DATA_W=16); expectations follow the build's early-exit option.
module tb_arm_alu_seq;
    import arm_alu_pkg::*;

    localparam int unsigned DW = 16;

`ifdef ARM_ALU_EARLY_EXIT_EN
    localparam int unsigned LAT_MUL37 = 2;
    localparam int unsigned LAT_MUL0  = 1;
`else
    localparam int unsigned LAT_MUL37 = 16;
    localparam int unsigned LAT_MUL0  = 16;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    arm_alu_seq_if #(.DATA_W(DW)) bus ();

    arm_alu_seq #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs after capture, then measure latency and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] rd,
                          input logic [15:0] rs, input logic cin, input int unsigned lat,
                          input logic [15:0] dexp, input logic [2:0] fexp);
        int unsigned n;
        logic        seen;
        bus.op      = op;
        bus.rd_data = rd;
        bus.rs_data = rs;
        bus.cin     = cin;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.rd_data = 16'($urandom);
        bus.rs_data = 16'($urandom);
        bus.cin     = 1'($urandom);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = bus.done;
        end
        check({tag, "_lat"}, seen ? 32'(n) : 32'hdead, 32'(lat));
        check({tag, "_dout"}, 32'(bus.d_out), 32'(dexp));
        check({tag, "_flags"}, 32'(bus.flags), 32'(fexp));
        tick();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, 32'(bus.d_out), 32'(dexp));
    endtask

    initial begin
        int unsigned n;
        int unsigned extra;
        logic        seen;

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = OP_ADD;
        bus.cin     = 1'b0;
        bus.rd_data = '0;
        bus.rs_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dout", 32'(bus.d_out), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);

        run_op("add", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 3'b011);
        run_op("sub", OP_SUB, 16'h0003, 16'h0005, 1'b0, 1, 16'hFFFE, 3'b100);
        run_op("mov", OP_MOV, 16'h0000, 16'h7FFF, 1'b1, 1, 16'h8000, 3'b100);
        run_op("lsr", OP_LSR, 16'h0000, 16'h0003, 1'b0, 1, 16'h0001, 3'b001);
        run_op("dec", OP_DEC, 16'h1234, 16'h0000, 1'b0, 1, 16'hFFFF, 3'b100);
        run_op("pass6", 3'b110, 16'h1234, 16'h5555, 1'b1, 1, 16'h1234, 3'b000);
        run_op("pass7", 3'b111, 16'h0000, 16'h5555, 1'b1, 1, 16'h0000, 3'b010);
        run_op("mul37", OP_MUL, 16'h0003, 16'h0007, 1'b0, LAT_MUL37, 16'h0015, 3'b000);
        run_op("mul0", OP_MUL, 16'h0000, 16'h1234, 1'b0, LAT_MUL0, 16'h0000, 3'b010);

        // Full-width multiply with start hammered for the whole busy window.
        bus.op      = OP_MUL;
        bus.rd_data = 16'hFFFF;
        bus.rs_data = 16'hFFFF;
        bus.start   = 1'b1;
        tick();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            bus.op      = OP_ADD;
            bus.rd_data = 16'($urandom);
            bus.rs_data = 16'($urandom);
            tick();
            n++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check("mulff_lat", seen ? 32'(n) : 32'hdead, 32'd16);
        check("mulff_dout", 32'(bus.d_out), 32'h0001);
        check("mulff_flags", 32'(bus.flags), 32'd0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done) extra++;
        end
        check("mulff_extra_done", 32'(extra), 32'd0);
        check("mulff_idle", 32'(bus.busy), 32'd0);

        // Start held high: each done cycle captures the next op.
        bus.op      = OP_ADD;
        bus.rd_data = 16'h0001;
        bus.rs_data = 16'h0002;
        bus.start   = 1'b1;
        tick();
        bus.op      = OP_SUB;
        bus.rd_data = 16'h0005;
        bus.rs_data = 16'h0003;
        tick();
        check("b2b_add_done", 32'(bus.done), 32'd1);
        check("b2b_add_dout", 32'(bus.d_out), 32'h0003);
        check("b2b_add_flags", 32'(bus.flags), 32'd0);
        tick();
        check("b2b_sub_busy", 32'(bus.busy), 32'd1);
        check("b2b_gap_done", 32'(bus.done), 32'd0);
        check("b2b_gap_dout", 32'(bus.d_out), 32'h0003);
        bus.op      = OP_MOV;
        bus.rd_data = 16'h0000;
        bus.rs_data = 16'h0000;
        bus.cin     = 1'b0;
        tick();
        check("b2b_sub_done", 32'(bus.done), 32'd1);
        check("b2b_sub_dout", 32'(bus.d_out), 32'h0002);
        check("b2b_sub_flags", 32'(bus.flags), 32'b001);
        tick();
        bus.start = 1'b0;
        check("b2b_mov_busy", 32'(bus.busy), 32'd1);
        check("b2b_gap2_flags", 32'(bus.flags), 32'b001);
        tick();
        check("b2b_mov_done", 32'(bus.done), 32'd1);
        check("b2b_mov_dout", 32'(bus.d_out), 32'h0000);
        check("b2b_mov_flags", 32'(bus.flags), 32'b010);

        // Load a nonzero result, then reset in the middle of a multiply.
        run_op("lsr2", OP_LSR, 16'h0000, 16'h8001, 1'b0, 1, 16'h4000, 3'b001);
        bus.op      = OP_MUL;
        bus.rd_data = 16'h0003;
        bus.rs_data = 16'h0007;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        extra = 0;
        tick();
        if (bus.done) extra++;
        tick();
        if (bus.done) extra++;
        rst_n = 1'b1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_dout", 32'(bus.d_out), 32'd0);
        check("mrst_flags", 32'(bus.flags), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) extra++;
        end
        check("mrst_no_done", 32'(extra), 32'd0);
        check("mrst_dout_after", 32'(bus.d_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
